fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controller that sequences instruction fetch against the instruction memory's syn/ack handshake.
- Owns the program counter and issues one request at a time.
- Presents the fetched instruction and its PC to decode with a valid/stall handshake.
- Handles branch redirect/flush, end-of-program (last) and memory timeout.
- Sits between the pipeline control (enable, stall, redirect) and the instruction memory port.

Parameters:
IWIDTH, 32, instruction width
PC_WIDTH, 32, program counter / address width
RESET_PC, 0, PC value after reset
PC_INC, 4, PC increment per consumed instruction
MAX_WAIT, 15, cycles in REQ without ack before timeout error (>=1)

Ports:
fs_clk  in  1  clock
fs_rst  in  1  reset, synchronous, active-high
fs_i_ce  in  1  fetch enable from pipeline control
fs_i_stall  in  1  decode not ready; hold presented instruction
fs_i_redirect  in  1  one-cycle pulse: flush and continue at fs_i_target
fs_i_target  in  PC_WIDTH  redirect PC
fs_o_syn  out  1  request to instruction memory (level, held until ack)
fs_o_addr  out  PC_WIDTH  request address
fs_i_ack  in  1  memory response strobe, one cycle
fs_i_instr  in  IWIDTH  memory data, valid with fs_i_ack
fs_i_last  in  1  qualifies ack: this word is the final instruction
fs_o_instr  out  IWIDTH  fetched instruction
fs_o_pc  out  PC_WIDTH  PC of fs_o_instr
fs_o_valid  out  1  fs_o_instr/fs_o_pc valid
fs_o_ce  out  1  stage advance = fs_o_valid & ~fs_i_stall (combinational)
fs_o_done  out  1  last instruction consumed; fetch halted
fs_o_err  out  1  sticky memory timeout

Behaviour:
- Reset (fs_rst=1 at a fs_clk edge):
  - State IDLE, pc=RESET_PC, timeout counter=0, drop flag=0.
  - Outputs: fs_o_syn=0, fs_o_addr=RESET_PC, fs_o_instr=0, fs_o_pc=0, fs_o_valid=0, fs_o_done=0, fs_o_err=0.
  - Reset overrides every other input.
- Registered outputs; only fs_o_ce is combinational.
- States:
  - IDLE: syn=0. ce=1 -> REQ.
  - REQ: syn=1, addr=pc, counter increments each cycle.
    - ack while drop=1: discard data, clear drop, stay in REQ for the new pc.
    - ack while drop=0: register instr, pc -> fs_o_instr/fs_o_pc, valid=1, latch last -> OUT.
    - counter reaching MAX_WAIT without ack -> ERR.
    - Counter clears on every entry to REQ.
  - OUT: valid=1, syn=0.
    - stall=1: hold all outputs unchanged.
    - stall=0 (consumed): valid->0, pc<=pc+PC_INC (modulo 2^PC_WIDTH, wraps silently). Next state: DONE if latched last, else REQ if ce, else IDLE.
  - DONE: done=1, syn=0, valid=0. Only redirect or reset leaves it.
  - ERR: err=1, syn=0, valid=0. Sticky; only reset leaves it.
- fs_i_ce=0 during REQ does not abandon the request; it completes normally and OUT exits to IDLE.
- Redirect (ignored in ERR) has priority over ack, last, stall and ce. In all cases pc<=fs_i_target.
  - In IDLE: go REQ next cycle if ce, else stay IDLE.
  - In REQ, no ack same cycle: set drop=1 and stay in REQ. syn stays high; the outstanding response is discarded on its ack. The new request is issued with addr=target after that ack.
  - In REQ with simultaneous ack: response discarded, drop stays 0, REQ with addr=target next cycle.
  - In OUT: valid->0 next cycle (flush, fs_o_ce suppressed from that cycle); go REQ if ce else IDLE.
  - In DONE: done->0; go REQ if ce else IDLE.
- Latency: syn high the cycle after entering REQ. Valid rises the cycle after ack. With 1-cycle memory and no stall, the cadence is one instruction per 3 cycles.
- ack outside REQ is ignored.

Test Plan:
- Reset 2 cycles, ce=1, memory acks 1 cycle after syn with instr=0xA000_0000+addr, last=0 -> valid with (pc,instr) = (0,0xA0000000), (4,0xA0000004), (8,0xA0000008), (12,0xA000000C), one every 3 cycles; fs_o_ce pulses with each valid.
- Stall=1 for 4 cycles while valid at pc=4 -> instr/pc/valid held, fs_o_ce=0, syn=0. On release: one fs_o_ce pulse, then next syn with addr=8.
- Redirect target=0x40 while syn=1 for addr=8, ack 2 cycles later -> that response never appears on valid; next syn addr=0x40, then valid with pc=0x40.
- Redirect in the same cycle as ack for addr=8 -> no valid for pc 8; next syn addr=0x40.
- ack with last=1 at addr=12 -> valid pc=12; after consumption done=1, syn stays 0. Redirect target=0 -> done=0, syn addr=0.
- No ack, MAX_WAIT=15 -> err=1 after 15 cycles of syn, syn=0, stays in ERR through redirects. Reset asserted mid-REQ -> next cycle syn=0, err=0, addr=0; a late ack is ignored.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: pipeline-control, decode and instruction-memory signals of the fetch sequencer
interface fetch_sequencer_if #(
    parameter int IWIDTH   = 32,
    parameter int PC_WIDTH = 32
);
    logic                fs_i_ce;
    logic                fs_i_stall;
    logic                fs_i_redirect;
    logic [PC_WIDTH-1:0] fs_i_target;
    logic                fs_o_syn;
    logic [PC_WIDTH-1:0] fs_o_addr;
    logic                fs_i_ack;
    logic [IWIDTH-1:0]   fs_i_instr;
    logic                fs_i_last;
    logic [IWIDTH-1:0]   fs_o_instr;
    logic [PC_WIDTH-1:0] fs_o_pc;
    logic                fs_o_valid;
    logic                fs_o_ce;
    logic                fs_o_done;
    logic                fs_o_err;

    modport master (
        input  fs_i_ce, fs_i_stall, fs_i_redirect, fs_i_target, fs_i_ack, fs_i_instr, fs_i_last,
        output fs_o_syn, fs_o_addr, fs_o_instr, fs_o_pc, fs_o_valid, fs_o_ce, fs_o_done, fs_o_err
    );

    modport slave (
        output fs_i_ce, fs_i_stall, fs_i_redirect, fs_i_target, fs_i_ack, fs_i_instr, fs_i_last,
        input  fs_o_syn, fs_o_addr, fs_o_instr, fs_o_pc, fs_o_valid, fs_o_ce, fs_o_done, fs_o_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and issues one instruction-memory request at a time toward decode
module fetch_sequencer #(
    parameter int IWIDTH   = 32,
    parameter int PC_WIDTH = 32,
    parameter int RESET_PC = 0,
    parameter int PC_INC   = 4,
    parameter int MAX_WAIT = 15
) (
    input logic fs_clk,
    input logic fs_rst,
    fetch_sequencer_if.master bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT - 1);
    localparam logic [PC_WIDTH-1:0] PC0 = PC_WIDTH'(RESET_PC);

    typedef enum logic [2:0] {IDLE, REQ, OUT, DONE, ERR} state_t;

    state_t              state, state_n;
    logic [PC_WIDTH-1:0] pc, pc_n, addr, opc;
    logic [CW-1:0]       cnt, cnt_n;
    logic                drop, drop_n, last, last_n, load;
    logic                syn, valid, done, err;
    logic [IWIDTH-1:0]   instr;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        drop_n  = drop;
        last_n  = last;
        load    = 1'b0;
        case (state)
            IDLE: begin
                pc_n    = bus.fs_i_redirect ? bus.fs_i_target : pc;
                state_n = bus.fs_i_ce ? REQ : IDLE;
            end
            REQ: begin
                if (bus.fs_i_ack) begin
                    // a redirect or a pending drop turns this response into a reissue at pc_n
                    cnt_n  = '0;
                    drop_n = 1'b0;
                    if (bus.fs_i_redirect) pc_n = bus.fs_i_target;
                    else if (!drop) begin
                        load    = 1'b1;
                        last_n  = bus.fs_i_last;
                        state_n = OUT;
                    end
                end else begin
                    if (bus.fs_i_redirect) begin
                        pc_n   = bus.fs_i_target;
                        drop_n = 1'b1;
                    end
                    if (cnt == CMAX) state_n = ERR;
                    else cnt_n = cnt + 1'b1;
                end
            end
            OUT: begin
                if (bus.fs_i_redirect) begin
                    pc_n    = bus.fs_i_target;
                    state_n = bus.fs_i_ce ? REQ : IDLE;
                end else if (!bus.fs_i_stall) begin
                    pc_n    = pc + PC_WIDTH'(PC_INC);
                    state_n = last ? DONE : bus.fs_i_ce ? REQ : IDLE;
                end
            end
            DONE: begin
                if (bus.fs_i_redirect) begin
                    pc_n    = bus.fs_i_target;
                    state_n = bus.fs_i_ce ? REQ : IDLE;
                end
            end
            default: ;
        endcase
        if (state_n == REQ && state != REQ) cnt_n = '0;
    end

    always_ff @(posedge fs_clk) begin
        if (fs_rst) begin
            state <= IDLE;
            pc    <= PC0;
            cnt   <= '0;
            drop  <= 1'b0;
            last  <= 1'b0;
            syn   <= 1'b0;
            addr  <= PC0;
            instr <= '0;
            opc   <= '0;
            valid <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            cnt   <= cnt_n;
            drop  <= drop_n;
            last  <= last_n;
            syn   <= state_n == REQ;
            // the address stays on the outstanding request until its response is dropped
            addr  <= drop_n ? addr : pc_n;
            if (load) begin
                instr <= bus.fs_i_instr;
                opc   <= pc;
            end
            valid <= state_n == OUT;
            done  <= state_n == DONE;
            err   <= state_n == ERR;
        end
    end

    assign bus.fs_o_syn   = syn;
    assign bus.fs_o_addr  = addr;
    assign bus.fs_o_instr = instr;
    assign bus.fs_o_pc    = opc;
    assign bus.fs_o_valid = valid;
    assign bus.fs_o_done  = done;
    assign bus.fs_o_err   = err;
    assign bus.fs_o_ce    = valid & ~bus.fs_i_stall;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch cadence, stall, redirect, last, timeout and reset
module tb_fetch_sequencer;
    logic fs_clk = 1'b0;
    logic fs_rst;
    logic auto_ack = 1'b0;
    logic pend = 1'b0;
    logic [31:0] last_at = 32'hFFFF_FFFF;
    int n_chk = 0;
    int n_err = 0;
    int n;

    always #5 fs_clk = ~fs_clk;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .fs_clk(fs_clk),
        .fs_rst(fs_rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance to the next falling edge; the memory model answers one cycle after it first sees syn
    task automatic cyc();
        @(negedge fs_clk);
        if (auto_ack) begin
            if (bus.fs_o_syn && pend) begin
                bus.fs_i_ack   = 1'b1;
                bus.fs_i_instr = 32'hA000_0000 + bus.fs_o_addr;
                bus.fs_i_last  = bus.fs_o_addr == last_at;
                pend = 1'b0;
            end else begin
                bus.fs_i_ack  = 1'b0;
                bus.fs_i_last = 1'b0;
                pend = bus.fs_o_syn;
            end
        end
    endtask

    task automatic wait_valid(input string tag, output int cycles);
        cycles = 0;
        do begin
            cyc();
            cycles++;
        end while (!bus.fs_o_valid && cycles < 30);
        if (!bus.fs_o_valid) check({tag, " valid timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        fs_rst = 1'b1;
        auto_ack = 1'b0;
        pend = 1'b0;
        bus.fs_i_ack = 1'b0;
        bus.fs_i_last = 1'b0;
        bus.fs_i_redirect = 1'b0;
        bus.fs_i_stall = 1'b0;
        cyc();
        cyc();
        fs_rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fs_rst = 1'b1;
        bus.fs_i_ce = 1'b1;
        bus.fs_i_stall = 1'b0;
        bus.fs_i_redirect = 1'b1;
        bus.fs_i_target = 32'h100;
        bus.fs_i_ack = 1'b1;
        bus.fs_i_instr = 32'h1234_5678;
        bus.fs_i_last = 1'b0;
        cyc();
        cyc();
        check("rst syn", bus.fs_o_syn, 0);
        check("rst addr", bus.fs_o_addr, 0);
        check("rst instr", bus.fs_o_instr, 0);
        check("rst pc", bus.fs_o_pc, 0);
        check("rst valid", bus.fs_o_valid, 0);
        check("rst done", bus.fs_o_done, 0);
        check("rst err", bus.fs_o_err, 0);

        // back-to-back fetches with a one-cycle memory
        do_reset();
        auto_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid("seq", n);
            check("seq cadence", n, 3);
            check("seq pc", bus.fs_o_pc, 4 * k);
            check("seq instr", bus.fs_o_instr, 32'hA000_0000 + 4 * k);
            check("seq ce", bus.fs_o_ce, 1);
        end

        // stall holds the presented instruction
        do_reset();
        auto_ack = 1'b1;
        wait_valid("stall pc0", n);
        wait_valid("stall pc4", n);
        check("stall pc", bus.fs_o_pc, 4);
        bus.fs_i_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("stall valid", bus.fs_o_valid, 1);
            check("stall hold pc", bus.fs_o_pc, 4);
            check("stall hold instr", bus.fs_o_instr, 32'hA000_0004);
            check("stall ce", bus.fs_o_ce, 0);
            check("stall syn", bus.fs_o_syn, 0);
        end
        bus.fs_i_stall = 1'b0;
        auto_ack = 1'b0;
        #1;
        check("release ce", bus.fs_o_ce, 1);
        cyc();
        check("release valid", bus.fs_o_valid, 0);
        check("release syn", bus.fs_o_syn, 1);
        check("release addr", bus.fs_o_addr, 8);

        // redirect while a request is outstanding; its late response is dropped
        bus.fs_i_redirect = 1'b1;
        bus.fs_i_target = 32'h40;
        cyc();
        bus.fs_i_redirect = 1'b0;
        check("drop syn", bus.fs_o_syn, 1);
        check("drop addr held", bus.fs_o_addr, 8);
        cyc();
        bus.fs_i_ack = 1'b1;
        bus.fs_i_instr = 32'hDEAD_BEEF;
        cyc();
        bus.fs_i_ack = 1'b0;
        check("drop valid", bus.fs_o_valid, 0);
        check("drop syn new", bus.fs_o_syn, 1);
        check("drop addr new", bus.fs_o_addr, 32'h40);
        auto_ack = 1'b1;
        pend = 1'b0;
        wait_valid("drop", n);
        check("drop pc", bus.fs_o_pc, 32'h40);
        check("drop instr", bus.fs_o_instr, 32'hA000_0040);

        // redirect in the same cycle as the ack
        do_reset();
        auto_ack = 1'b1;
        wait_valid("same pc0", n);
        wait_valid("same pc4", n);
        auto_ack = 1'b0;
        cyc();
        check("same addr8", bus.fs_o_addr, 8);
        bus.fs_i_ack = 1'b1;
        bus.fs_i_instr = 32'hDEAD_0008;
        bus.fs_i_redirect = 1'b1;
        bus.fs_i_target = 32'h40;
        cyc();
        bus.fs_i_ack = 1'b0;
        bus.fs_i_redirect = 1'b0;
        check("same valid", bus.fs_o_valid, 0);
        check("same syn", bus.fs_o_syn, 1);
        check("same addr", bus.fs_o_addr, 32'h40);
        auto_ack = 1'b1;
        pend = 1'b0;
        wait_valid("same", n);
        check("same pc", bus.fs_o_pc, 32'h40);

        // last instruction halts fetch until a redirect
        do_reset();
        last_at = 32'd12;
        auto_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid("last", n);
            check("last pc", bus.fs_o_pc, 4 * k);
        end
        check("last done early", bus.fs_o_done, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("done", bus.fs_o_done, 1);
            check("done syn", bus.fs_o_syn, 0);
            check("done valid", bus.fs_o_valid, 0);
        end
        last_at = 32'hFFFF_FFFF;
        bus.fs_i_redirect = 1'b1;
        bus.fs_i_target = 32'h0;
        cyc();
        bus.fs_i_redirect = 1'b0;
        auto_ack = 1'b0;
        bus.fs_i_ack = 1'b0;
        check("undone", bus.fs_o_done, 0);
        check("undone syn", bus.fs_o_syn, 1);
        check("undone addr", bus.fs_o_addr, 0);

        // no ack: timeout after MAX_WAIT cycles of syn, sticky through redirects
        n = 0;
        while (bus.fs_o_syn && n < 40) begin
            n++;
            cyc();
        end
        check("timeout cycles", n, 15);
        check("timeout err", bus.fs_o_err, 1);
        check("timeout syn", bus.fs_o_syn, 0);
        bus.fs_i_redirect = 1'b1;
        bus.fs_i_target = 32'h80;
        cyc();
        cyc();
        bus.fs_i_redirect = 1'b0;
        cyc();
        check("err sticky", bus.fs_o_err, 1);
        check("err syn", bus.fs_o_syn, 0);
        check("err valid", bus.fs_o_valid, 0);

        // reset mid-request, then a late ack outside REQ
        fs_rst = 1'b1;
        cyc();
        check("rst err clr", bus.fs_o_err, 0);
        fs_rst = 1'b0;
        cyc();
        check("req syn", bus.fs_o_syn, 1);
        cyc();
        fs_rst = 1'b1;
        cyc();
        check("midrst syn", bus.fs_o_syn, 0);
        check("midrst err", bus.fs_o_err, 0);
        check("midrst addr", bus.fs_o_addr, 0);
        fs_rst = 1'b0;
        bus.fs_i_ce = 1'b0;
        bus.fs_i_ack = 1'b1;
        bus.fs_i_instr = 32'h0BAD_0BAD;
        cyc();
        bus.fs_i_ack = 1'b0;
        check("late ack valid", bus.fs_o_valid, 0);
        check("late ack syn", bus.fs_o_syn, 0);
        cyc();
        check("late ack instr", bus.fs_o_instr, 0);
        check("late ack valid2", bus.fs_o_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
